dtm_dmi_master: RTL and testbench
=================================

Name: dtm_dmi_master

Overview:
- DTM-side DMI initiator. It is the requester end of the dtm_req/dm_resp bus into the Debug Module register block.
- Accepts one DMI access per update pulse from the DTM scan logic, already synchronised to sys_clk.
- Drives dtm_req_valid/bits and waits for dtm_req_ready. For reads, it also waits for dm_resp_valid and captures the read data.
- Keeps RISC-V dmi sticky status (0 ok, 2 failed, 3 busy) for the scan chain to capture.

Parameters:
- ADDR_W, 7, DMI address width (equals DBUS_ADDR_WIDTH).
- DATA_W, 32, DMI data width (equals DBUS_DATA_WIDTH).
- TIMEOUT, 255, cycles to wait for a read response before declaring failure. Valid range 1..65535.

Ports:
- sys_clk  in  1  clock.
- sys_rstn  in  1  asynchronous active-low reset.
- dmi_update  in  1  one-cycle pulse; launches the access given by dmi_op/dmi_addr/dmi_wdata.
- dmi_op  in  2  0 nop, 1 read, 2 write, 3 reserved.
- dmi_addr  in  ADDR_W  target DM register address.
- dmi_wdata  in  DATA_W  write data.
- dmireset  in  1  one-cycle pulse; clears sticky status.
- dmi_rdata  out  DATA_W  last captured read data.
- dmi_status  out  2  sticky status: 0, 2 or 3.
- dmi_busy  out  1  access in flight (FSM not IDLE).
- dtm_req_valid  out  1  request valid.
- dtm_req_ready  in  1  DM can accept a request.
- dtm_req_bits  out  2+ADDR_W+DATA_W  request word: {data, addr, op}; op in [1:0], addr in [ADDR_W+1:2], data in the top DATA_W bits.
- dm_resp_valid  in  1  response valid.
- dm_resp_ready  out  1  response accept.
- dm_resp_bits  in  2+DATA_W  response word: {op, data}; data in [DATA_W-1:0].

Behaviour:
- Reset values:
  - state IDLE, dtm_req_valid 0, dtm_req_bits 0, dm_resp_ready 0.
  - dmi_rdata 0, dmi_status 0, dmi_busy 0, timeout counter 0.
- All outputs are registered.
- FSM states:
  - IDLE → REQ: on dmi_update when dmi_status==0 and op is 1 or 2. Latch {wdata, addr, op} into dtm_req_bits; dtm_req_valid=1 from the next cycle.
  - IDLE, op 0: no request issued, no state change.
  - IDLE, op 3: no request issued; dmi_status<=2.
  - IDLE, dmi_update while dmi_status!=0: ignored entirely, no request issued.
  - REQ: hold dtm_req_valid=1 and dtm_req_bits stable until dtm_req_ready=1 in the same cycle. Then drop valid the next cycle. Go to IDLE if the op was a write, or WAIT_RESP if a read. No timeout in REQ; a stalled DM is reported as busy.
  - WAIT_RESP:
    - dm_resp_ready=1. On dm_resp_valid: dmi_rdata<=dm_resp_bits[DATA_W-1:0], go to IDLE.
    - Counter increments each cycle. When it reaches TIMEOUT-1 without a response: dmi_status<=2, dmi_rdata unchanged, go to IDLE.
    - A response in the same cycle as the timeout wins: data captured, no error.
- Best-case read latency: update at cycle 0 → valid at 1 → ready at 1 → WAIT_RESP at 2. A response at 2 is captured; dmi_rdata is valid at 3 and dmi_busy=0 at 3.
- dm_resp_ready=0 outside WAIT_RESP.
- Busy collision: dmi_update while dmi_busy=1 sets dmi_status<=3. The in-flight access completes normally; the new access is dropped.
- Status is sticky: 2 and 3 persist until dmireset. If a timeout (2) and a busy collision (3) happen in the same cycle, 3 wins.
- dmireset:
  - Clears dmi_status to 0 only. It does not abort an in-flight access.
  - dmireset and dmi_update in the same cycle: dmireset applies first, then the update is evaluated against status 0.
- Reset mid-operation: everything returns to reset values immediately; the outstanding DM transaction is abandoned.

Decomposition:
- In dbg_defines.vh:
  - DMI op codes (NOP/RD/WR) and status codes (OK/FAILED/BUSY).
  - DBUS field widths and offsets.
  - FSM state encodings (2 bits).
- No sub-module: the FSM plus a $clog2(TIMEOUT+1)-bit counter sit in one file.

Test Plan:
- Write data0: update op=2, addr=0x04, data=0xDEADBEEF, ready=1 → one-cycle dtm_req_valid with bits {0xDEADBEEF, 0x04, 2'b10}; no dm_resp_ready; status 0.
- Read data0: op=1, addr=0x04; DM returns 0x12345678 one cycle after acceptance → dmi_rdata=0x12345678, status 0, busy low 3 cycles after update.
- Backpressure: dtm_req_ready held low 10 cycles → valid and bits stable all 10 cycles. An update in that window sets status=3, the original access still completes, and a later update is ignored until dmireset → status 0.
- Timeout with TIMEOUT=8: read, no dm_resp_valid → status=2 after 8 cycles in WAIT_RESP; dmi_rdata keeps its old value.
- Reserved and nop ops: op=3 → status=2 with no request; op=0 → no request, status 0, busy 0.
- Reset mid-read: assert sys_rstn low while in WAIT_RESP → all outputs 0 asynchronously; after release, a new read works normally.

Source files
------------

// File: rtl/dtm_dmi_master_pkg.sv
// Shared definitions for the DTM-side DMI initiator: op/status codes, bus field layout, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dtm_dmi_master_pkg;

  // DMI bus field widths and where each field sits in the request word
  localparam int DBUS_ADDR_WIDTH = 7;
  localparam int DBUS_DATA_WIDTH = 32;
  localparam int DBUS_OP_WIDTH   = 2;
  localparam int DBUS_OP_LSB     = 0;
  localparam int DBUS_ADDR_LSB   = DBUS_OP_LSB + DBUS_OP_WIDTH;

  // DMI op codes as seen on the scan chain and in the request word
  typedef enum logic [1:0] {
    DMI_OP_NOP  = 2'd0,
    DMI_OP_RD   = 2'd1,
    DMI_OP_WR   = 2'd2,
    DMI_OP_RSVD = 2'd3
  } dmi_op_e;

  // Sticky dmi status codes captured by the scan chain
  localparam logic [1:0] DMI_ST_OK     = 2'd0;
  localparam logic [1:0] DMI_ST_FAILED = 2'd2;
  localparam logic [1:0] DMI_ST_BUSY   = 2'd3;

  // Initiator FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2
  } dmi_state_e;

  // True for the two ops that actually reach the Debug Module
  function automatic logic dmi_op_is_access(input logic [1:0] op);
    return (op == DMI_OP_RD) || (op == DMI_OP_WR);
  endfunction

endpackage

// File: rtl/dtm_dmi_master_if.sv
// Request/response bus between the DTM initiator (master) and the Debug Module register block (slave).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the request and the response channel.
interface dtm_dmi_master_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);

  logic                       dtm_req_valid;
  logic                       dtm_req_ready;
  logic [2+ADDR_W+DATA_W-1:0] dtm_req_bits;
  logic                       dm_resp_valid;
  logic                       dm_resp_ready;
  logic [2+DATA_W-1:0]        dm_resp_bits;

  modport master (
    output dtm_req_valid,
    output dtm_req_bits,
    output dm_resp_ready,
    input  dtm_req_ready,
    input  dm_resp_valid,
    input  dm_resp_bits
  );

  modport slave (
    input  dtm_req_valid,
    input  dtm_req_bits,
    input  dm_resp_ready,
    output dtm_req_ready,
    output dm_resp_valid,
    output dm_resp_bits
  );

endinterface

// File: rtl/dtm_dmi_master.sv
// DTM-side DMI initiator: one DM access per dmi_update pulse, with sticky RISC-V dmi status.
// Latency: update->req_valid 1 cycle; best-case read data/busy-clear 3 cycles after update.
// Backpressure: holds request until dtm_req_ready; waits up to TIMEOUT cycles for a read response.
module dtm_dmi_master
  import dtm_dmi_master_pkg::*;
#(
  parameter int ADDR_W  = DBUS_ADDR_WIDTH,
  parameter int DATA_W  = DBUS_DATA_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              dmi_update,
  input  logic [1:0]        dmi_op,
  input  logic [ADDR_W-1:0] dmi_addr,
  input  logic [DATA_W-1:0] dmi_wdata,
  input  logic              dmireset,
  output logic [DATA_W-1:0] dmi_rdata,
  output logic [1:0]        dmi_status,
  output logic              dmi_busy,
  dtm_dmi_master_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  dmi_state_e       state;
  logic [CNT_W-1:0] tmo_cnt;

  logic [1:0] status_base;
  logic       resp_hit;
  logic       tmo_hit;
  logic       collide;
  logic       launch;
  logic       rsvd_hit;
  logic       unused_resp_op;

  // The response op field carries nothing the initiator needs
  assign unused_resp_op = ^bus.dm_resp_bits[DATA_W+1:DATA_W];

  // Decode this cycle's events; dmireset is folded in before any update is judged
  always_comb begin
    status_base = dmireset ? DMI_ST_OK : dmi_status;
    resp_hit    = (state == ST_WAIT_RESP) && bus.dm_resp_valid;
    tmo_hit     = (state == ST_WAIT_RESP) && !bus.dm_resp_valid &&
                  (tmo_cnt == CNT_W'(TIMEOUT - 1));
    collide     = dmi_update && dmi_busy;
    launch      = (state == ST_IDLE) && dmi_update && (status_base == DMI_ST_OK) &&
                  dmi_op_is_access(dmi_op);
    rsvd_hit    = (state == ST_IDLE) && dmi_update && (status_base == DMI_ST_OK) &&
                  (dmi_op == DMI_OP_RSVD);
  end

  // Initiator FSM with registered bus outputs, read capture, timeout counter and sticky status
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state             <= ST_IDLE;
      tmo_cnt           <= '0;
      dmi_rdata         <= '0;
      dmi_status        <= DMI_ST_OK;
      dmi_busy          <= 1'b0;
      bus.dtm_req_valid <= 1'b0;
      bus.dtm_req_bits  <= '0;
      bus.dm_resp_ready <= 1'b0;
    end else begin
      // Busy collision outranks a same-cycle timeout
      if (collide) begin
        dmi_status <= DMI_ST_BUSY;
      end else if (tmo_hit || rsvd_hit) begin
        dmi_status <= DMI_ST_FAILED;
      end else begin
        dmi_status <= status_base;
      end

      case (state)
        ST_IDLE: begin
          if (launch) begin
            bus.dtm_req_bits  <= {dmi_wdata, dmi_addr, dmi_op};
            bus.dtm_req_valid <= 1'b1;
            dmi_busy          <= 1'b1;
            state             <= ST_REQ;
          end
        end

        ST_REQ: begin
          // No timeout here: a stalled DM shows up to the debugger as busy
          if (bus.dtm_req_ready) begin
            bus.dtm_req_valid <= 1'b0;
            if (bus.dtm_req_bits[DBUS_ADDR_LSB-1:DBUS_OP_LSB] == DMI_OP_RD) begin
              bus.dm_resp_ready <= 1'b1;
              tmo_cnt           <= '0;
              state             <= ST_WAIT_RESP;
            end else begin
              dmi_busy <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end

        ST_WAIT_RESP: begin
          // A response arriving on the timeout cycle still counts as success
          if (resp_hit) begin
            dmi_rdata         <= bus.dm_resp_bits[DATA_W-1:0];
            bus.dm_resp_ready <= 1'b0;
            dmi_busy          <= 1'b0;
            tmo_cnt           <= '0;
            state             <= ST_IDLE;
          end else if (tmo_hit) begin
            bus.dm_resp_ready <= 1'b0;
            dmi_busy          <= 1'b0;
            tmo_cnt           <= '0;
            state             <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        default: begin
          bus.dtm_req_valid <= 1'b0;
          bus.dm_resp_ready <= 1'b0;
          dmi_busy          <= 1'b0;
          tmo_cnt           <= '0;
          state             <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtm_dmi_master.sv
// Scoreboard bench for dtm_dmi_master: requests and access completions are checked by a monitor.
// Latency: drives inputs 1ns after posedge, samples on negedge.
// Backpressure: dtm_req_ready and dm_resp_valid are driven directly by the stimulus.
module tb_dtm_dmi_master;

  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int RW  = 2 + AW + DW;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    status;
  } cpl_t;

  logic          sys_clk  = 1'b0;
  logic          sys_rstn = 1'b1;
  logic          dmi_update = 1'b0;
  logic [1:0]    dmi_op     = 2'd0;
  logic [AW-1:0] dmi_addr   = '0;
  logic [DW-1:0] dmi_wdata  = '0;
  logic          dmireset   = 1'b0;
  logic [DW-1:0] dmi_rdata;
  logic [1:0]    dmi_status;
  logic          dmi_busy;

  int checks = 0;
  int errors = 0;
  int req_vld_cycles  = 0;
  int resp_rdy_cycles = 0;
  logic prev_busy = 1'b0;

  logic [RW-1:0] exp_req_q[$];
  cpl_t          exp_cpl_q[$];
  cpl_t          cpl_e;
  logic [RW-1:0] req_e;
  logic [RW-1:0] stall_bits;

  always #5 sys_clk = ~sys_clk;

  dtm_dmi_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dtm_dmi_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .sys_clk    (sys_clk),
    .sys_rstn   (sys_rstn),
    .dmi_update (dmi_update),
    .dmi_op     (dmi_op),
    .dmi_addr   (dmi_addr),
    .dmi_wdata  (dmi_wdata),
    .dmireset   (dmireset),
    .dmi_rdata  (dmi_rdata),
    .dmi_status (dmi_status),
    .dmi_busy   (dmi_busy),
    .bus        (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One-cycle update pulse (optionally with dmireset in the same cycle); returns in the following cycle
  task automatic update(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic with_reset);
    tick();
    dmi_update = 1'b1;
    dmi_op     = op;
    dmi_addr   = a;
    dmi_wdata  = d;
    dmireset   = with_reset;
    tick();
    dmi_update = 1'b0;
    dmireset   = 1'b0;
  endtask

  task automatic pulse_dmireset();
    tick();
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
  endtask

  task automatic respond(input logic [DW-1:0] d);
    tick();
    bus.dm_resp_valid = 1'b1;
    bus.dm_resp_bits  = {2'b11, d};
    tick();
    bus.dm_resp_valid = 1'b0;
    bus.dm_resp_bits  = '0;
  endtask

  // Monitor: pops expected request on each handshake and expected result on each busy fall
  always @(negedge sys_clk) begin
    if (!sys_rstn) begin
      prev_busy = 1'b0;
    end else begin
      if (bus.dtm_req_valid) req_vld_cycles++;
      if (bus.dm_resp_ready) resp_rdy_cycles++;
      if (bus.dtm_req_valid && bus.dtm_req_ready) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: got bits %0h expected no request", bus.dtm_req_bits);
        end else begin
          req_e = exp_req_q.pop_front();
          check("req_bits", 64'(bus.dtm_req_bits), 64'(req_e));
        end
      end
      if (prev_busy && !dmi_busy) begin
        if (exp_cpl_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpl_unexpected: got rdata %0h status %0d expected no completion",
                   dmi_rdata, dmi_status);
        end else begin
          cpl_e = exp_cpl_q.pop_front();
          check("cpl_rdata", 64'(dmi_rdata), 64'(cpl_e.rdata));
          check("cpl_status", 64'(dmi_status), 64'(cpl_e.status));
        end
      end
      prev_busy = dmi_busy;
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dtm_req_ready = 1'b0;
    bus.dm_resp_valid = 1'b0;
    bus.dm_resp_bits  = '0;

    // Reset state
    #1 sys_rstn = 1'b0;
    #10;
    check("rst_req_valid", 64'(bus.dtm_req_valid), 64'd0);
    check("rst_req_bits", 64'(bus.dtm_req_bits), 64'd0);
    check("rst_resp_ready", 64'(bus.dm_resp_ready), 64'd0);
    check("rst_rdata", 64'(dmi_rdata), 64'd0);
    check("rst_status", 64'(dmi_status), 64'd0);
    check("rst_busy", 64'(dmi_busy), 64'd0);
    tick();
    sys_rstn = 1'b1;
    tick();

    // Write: single-cycle request, never asks for a response
    bus.dtm_req_ready = 1'b1;
    req_vld_cycles  = 0;
    resp_rdy_cycles = 0;
    exp_req_q.push_back({32'hDEADBEEF, 7'h04, 2'b10});
    exp_cpl_q.push_back('{rdata: 32'h0, status: 2'd0});
    update(2'd2, 7'h04, 32'hDEADBEEF, 1'b0);
    repeat (3) tick();
    check("wr_valid_cycles", 64'(req_vld_cycles), 64'd1);
    check("wr_no_resp_ready", 64'(resp_rdy_cycles), 64'd0);
    check("wr_status", 64'(dmi_status), 64'd0);

    // Read, best case: response one cycle after acceptance, done 3 cycles after update
    exp_req_q.push_back({32'h0, 7'h04, 2'b01});
    exp_cpl_q.push_back('{rdata: 32'h12345678, status: 2'd0});
    update(2'd1, 7'h04, 32'h0, 1'b0);
    respond(32'h12345678);
    check("rd_busy_c3", 64'(dmi_busy), 64'd0);
    check("rd_rdata_c3", 64'(dmi_rdata), 64'h12345678);

    // Backpressure with a busy collision in the stall window
    bus.dtm_req_ready = 1'b0;
    stall_bits = {32'h11112222, 7'h10, 2'b01};
    exp_req_q.push_back(stall_bits);
    exp_cpl_q.push_back('{rdata: 32'hCAFEF00D, status: 2'd3});
    update(2'd1, 7'h10, 32'h11112222, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("bp_valid", 64'(bus.dtm_req_valid), 64'd1);
      check("bp_bits", 64'(bus.dtm_req_bits), 64'(stall_bits));
    end
    update(2'd2, 7'h20, 32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("bp_valid2", 64'(bus.dtm_req_valid), 64'd1);
      check("bp_bits2", 64'(bus.dtm_req_bits), 64'(stall_bits));
    end
    check("bp_status_busy", 64'(dmi_status), 64'd3);
    tick();
    bus.dtm_req_ready = 1'b1;
    respond(32'hCAFEF00D);
    req_vld_cycles = 0;
    update(2'd2, 7'h08, 32'h0F0F0F0F, 1'b0);
    repeat (3) tick();
    check("sticky_no_req", 64'(req_vld_cycles), 64'd0);
    check("sticky_busy", 64'(dmi_busy), 64'd0);
    check("sticky_status", 64'(dmi_status), 64'd3);
    pulse_dmireset();
    check("dmireset_status", 64'(dmi_status), 64'd0);

    // Read timeout: 8 cycles waiting, old data kept
    resp_rdy_cycles = 0;
    exp_req_q.push_back({32'h0, 7'h11, 2'b01});
    exp_cpl_q.push_back('{rdata: 32'hCAFEF00D, status: 2'd2});
    update(2'd1, 7'h11, 32'h0, 1'b0);
    repeat (12) tick();
    check("tmo_wait_cycles", 64'(resp_rdy_cycles), 64'd8);
    check("tmo_status", 64'(dmi_status), 64'd2);
    check("tmo_rdata", 64'(dmi_rdata), 64'hCAFEF00D);

    // dmireset together with update: the read proceeds against cleared status
    exp_req_q.push_back({32'h0, 7'h12, 2'b01});
    exp_cpl_q.push_back('{rdata: 32'h5A5A5A5A, status: 2'd0});
    update(2'd1, 7'h12, 32'h0, 1'b1);
    respond(32'h5A5A5A5A);
    check("rst_upd_status", 64'(dmi_status), 64'd0);

    // Reserved op fails without a request; nop does nothing
    req_vld_cycles = 0;
    update(2'd3, 7'h05, 32'h0, 1'b0);
    tick();
    check("rsvd_status", 64'(dmi_status), 64'd2);
    check("rsvd_busy", 64'(dmi_busy), 64'd0);
    check("rsvd_no_req", 64'(req_vld_cycles), 64'd0);
    pulse_dmireset();
    update(2'd0, 7'h06, 32'h0, 1'b0);
    repeat (2) tick();
    check("nop_status", 64'(dmi_status), 64'd0);
    check("nop_busy", 64'(dmi_busy), 64'd0);
    check("nop_no_req", 64'(req_vld_cycles), 64'd0);

    // Reset while waiting for a read response
    exp_req_q.push_back({32'h0, 7'h13, 2'b01});
    update(2'd1, 7'h13, 32'h0, 1'b0);
    tick();
    check("mid_in_wait", 64'(bus.dm_resp_ready), 64'd1);
    #2 sys_rstn = 1'b0;
    #1;
    check("mid_req_valid", 64'(bus.dtm_req_valid), 64'd0);
    check("mid_req_bits", 64'(bus.dtm_req_bits), 64'd0);
    check("mid_resp_ready", 64'(bus.dm_resp_ready), 64'd0);
    check("mid_rdata", 64'(dmi_rdata), 64'd0);
    check("mid_status", 64'(dmi_status), 64'd0);
    check("mid_busy", 64'(dmi_busy), 64'd0);
    tick();
    tick();
    sys_rstn = 1'b1;
    tick();
    exp_req_q.push_back({32'h0, 7'h04, 2'b01});
    exp_cpl_q.push_back('{rdata: 32'h0BADCAFE, status: 2'd0});
    update(2'd1, 7'h04, 32'h0, 1'b0);
    respond(32'h0BADCAFE);
    check("post_rst_rdata", 64'(dmi_rdata), 64'h0BADCAFE);
    check("post_rst_busy", 64'(dmi_busy), 64'd0);

    repeat (3) tick();
    check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
    check("cpl_queue_drained", 64'(exp_cpl_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
